pio_cmd_responder: RTL and testbench

// - FPGA-fabric responder for the HPS->FPGA command channel carried on the soc_system PIO exports.
// - HPS writes {req_toggle, opcode[2:0]} to pio_0 (output[3:0]); this block decodes the command, executes it,
//   and returns {ack_toggle, err} on pio_1 (input[1:0]).
// - Drives fabric control strobes and the active-low hps_0_f2h_warm_reset_req_reset_n request.

---
 rtl/pio_resp_pkg.sv | 29 ++
 rtl/pio_cmd_responder_sync.sv | 26 ++
 rtl/pio_cmd_responder.sv | 176 +++++++++++++++++
 tb/tb_pio_cmd_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pio_resp_pkg.sv
// Shared opcode/state types and PIO bit positions for the HPS command responder.
// Optional WAIT_DONE timeout is selected with PIO_RESP_TIMEOUT_EN in pio_cmd_responder.
package pio_resp_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_ARM       = 3'd1,
    OP_DISARM    = 3'd2,
    OP_TRIG      = 3'd3,
    OP_CLEAR     = 3'd4,
    OP_WARM_RST  = 3'd5,
    OP_RSVD      = 3'd6,
    OP_WAIT_DONE = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_EXEC,
    S_PULSE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam int REQ_BIT = 3;
  localparam int ACK_BIT = 1;
  localparam int ERR_BIT = 0;

endpackage

// File: rtl/pio_cmd_responder_sync.sv
// Multi-flop synchronizer for the asynchronous PIO command word.
// All stages clear on the synchronous reset.
module pio_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ff [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pio_cmd_responder.sv
// HPS->FPGA PIO command responder: toggle handshake, decode, strobes, warm reset.
// Define PIO_RESP_TIMEOUT_EN to bound WAIT_DONE by TIMEOUT_CYC cycles.
module pio_cmd_responder
  import pio_resp_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE_CYC = 16,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       pio_cmd_i,
  output logic [1:0]       pio_stat_o,
  input  logic             done_i,
  output logic             arm_o,
  output logic             trig_o,
  output logic             clr_o,
  output logic             warm_reset_req_n_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cmd_count_o
);

`ifdef PIO_RESP_TIMEOUT_EN
  localparam int LIM = (TIMEOUT_CYC > RST_PULSE_CYC) ?
                       TIMEOUT_CYC : RST_PULSE_CYC;
`else
  localparam int LIM = RST_PULSE_CYC;
`endif
  localparam int TW = (LIM > 1) ? $clog2(LIM) : 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (RST_PULSE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cyc
    $error("RST_PULSE_CYC and TIMEOUT_CYC must be >= 1");
  end

  logic [3:0]       cmd_s;
  logic             req_s;
  op_e              op_s;
  state_e           state_q;
  state_e           state_d;
  op_e              op_q;
  logic             ack_q;
  logic             err_q;
  logic             stat_err_q;
  logic             arm_q;
  logic             trig_q;
  logic             clr_q;
  logic             warm_n_q;
  logic             nocount_q;
  logic [TW-1:0]    cnt_q;
  logic             cnt_zero;
  logic [CNT_W-1:0] count_q;

  pio_sync #(
    .W      (4),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pio_cmd_i),
    .q     (cmd_s)
  );

  assign req_s    = cmd_s[REQ_BIT];
  assign op_s     = op_e'(cmd_s[2:0]);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (req_s != ack_q) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          (op_q == OP_WARM_RST):  state_d = S_PULSE;
          (op_q == OP_WAIT_DONE): state_d = S_WAIT;
          default:                state_d = S_ACK;
        endcase
      end
      S_PULSE:   if (cnt_zero) state_d = S_ACK;
      S_WAIT: begin
        if (done_i) state_d = S_ACK;
`ifdef PIO_RESP_TIMEOUT_EN
        else if (cnt_zero) state_d = S_ACK;
`endif
      end
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_NOP;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      stat_err_q <= 1'b0;
      arm_q      <= 1'b0;
      trig_q     <= 1'b0;
      clr_q      <= 1'b0;
      warm_n_q   <= 1'b1;
      nocount_q  <= 1'b0;
      cnt_q      <= '0;
      count_q    <= '0;
    end else begin
      trig_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        S_CAPTURE: op_q <= op_s;
        S_EXEC: begin
          err_q     <= 1'b0;
          nocount_q <= 1'b0;
          case (op_q)
            OP_ARM:    arm_q <= 1'b1;
            OP_DISARM: arm_q <= 1'b0;
            OP_TRIG: begin
              if (arm_q) trig_q <= 1'b1;
              else       err_q  <= 1'b1;
            end
            OP_CLEAR: begin
              clr_q     <= 1'b1;
              count_q   <= '0;
              nocount_q <= 1'b1;
            end
            OP_WARM_RST: begin
              warm_n_q <= 1'b0;
              cnt_q    <= TW'(RST_PULSE_CYC - 1);
            end
`ifdef PIO_RESP_TIMEOUT_EN
            OP_WAIT_DONE: cnt_q <= TW'(TIMEOUT_CYC - 1);
`endif
            OP_RSVD:   err_q <= 1'b1;
            default: ;
          endcase
        end
        S_PULSE: begin
          if (cnt_zero) warm_n_q <= 1'b1;
          else          cnt_q    <= cnt_q - 1'b1;
        end
`ifdef PIO_RESP_TIMEOUT_EN
        // done_i wins over expiry in the same cycle
        S_WAIT: begin
          if (!done_i) begin
            if (cnt_zero) err_q <= 1'b1;
            else          cnt_q <= cnt_q - 1'b1;
          end
        end
`endif
        S_ACK: begin
          ack_q      <= ~ack_q;
          stat_err_q <= err_q;
          if (!nocount_q) count_q <= count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pio_stat_o[ACK_BIT] = ack_q;
  assign pio_stat_o[ERR_BIT] = stat_err_q;
  assign arm_o               = arm_q;
  assign trig_o              = trig_q;
  assign clr_o               = clr_q;
  assign warm_reset_req_n_o  = warm_n_q;
  assign busy_o              = (state_q != S_IDLE);
  assign cmd_count_o         = count_q;

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Directed self-checking bench for pio_cmd_responder.
// Build with PIO_RESP_TIMEOUT_EN to also cover the WAIT_DONE timeout.
module tb_pio_cmd_responder;

  localparam int SYNC   = 2;
  localparam int PULSE  = 16;
  localparam int TMO    = 64;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    pio_cmd_i;
  logic [1:0]    pio_stat_o;
  logic          done_i;
  logic          arm_o;
  logic          trig_o;
  logic          clr_o;
  logic          warm_reset_req_n_o;
  logic          busy_o;
  logic [CW-1:0] cmd_count_o;

  int  n_pass = 0;
  int  n_total = 0;
  logic req = 1'b0;
  int  lat, trig_n, trig_at, clr_n, clr_at, warm_low, busy_viol;

  pio_cmd_responder #(
    .SYNC_STAGES   (SYNC),
    .RST_PULSE_CYC (PULSE),
    .TIMEOUT_CYC   (TMO),
    .CNT_W         (CW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pio_cmd_i          (pio_cmd_i),
    .pio_stat_o         (pio_stat_o),
    .done_i             (done_i),
    .arm_o              (arm_o),
    .trig_o             (trig_o),
    .clr_o              (clr_o),
    .warm_reset_req_n_o (warm_reset_req_n_o),
    .busy_o             (busy_o),
    .cmd_count_o        (cmd_count_o)
  );

  always #5 clk = ~clk;

  // Toggle req with opcode op just after an edge and follow it to its ack.
  task automatic run_cmd(input logic [2:0] op, input int done_at);
    lat = 0; trig_n = 0; trig_at = 0; clr_n = 0; clr_at = 0;
    warm_low = 0; busy_viol = 0;
    req = ~req;
    pio_cmd_i = {req, op};
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (trig_o) begin trig_n++; trig_at = lat; end
      if (clr_o) begin clr_n++; clr_at = lat; end
      if (!warm_reset_req_n_o) begin
        warm_low++;
        if (!busy_o) busy_viol++;
      end
      if (done_at > 0 && lat == done_at) done_i = 1'b1;
      if (pio_stat_o[1] == req) break;
      if (lat >= 400) begin
        n_total++;
        $display("FAIL ack_wait op=%0d: no ack after %0d cycles", op, lat);
        break;
      end
    end
    done_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; pio_cmd_i = 4'h0; done_i = 1'b0; req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_total++; if (pio_stat_o !== 2'b00) $display("FAIL rst_stat: got %b want 00", pio_stat_o); else n_pass++;
    n_total++; if (arm_o !== 1'b0) $display("FAIL rst_arm: got %b want 0", arm_o); else n_pass++;
    n_total++; if (trig_o !== 1'b0) $display("FAIL rst_trig: got %b want 0", trig_o); else n_pass++;
    n_total++; if (clr_o !== 1'b0) $display("FAIL rst_clr: got %b want 0", clr_o); else n_pass++;
    n_total++; if (warm_reset_req_n_o !== 1'b1) $display("FAIL rst_warm: got %b want 1", warm_reset_req_n_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (cmd_count_o !== 4'd0) $display("FAIL rst_count: got %0d want 0", cmd_count_o); else n_pass++;
  endtask

  task automatic test_arm;
    run_cmd(3'd1, 0);
    n_total++; if (lat !== SYNC + 4) $display("FAIL arm_lat: got %0d want %0d", lat, SYNC + 4); else n_pass++;
    n_total++; if (pio_stat_o !== 2'b10) $display("FAIL arm_stat: got %b want 10", pio_stat_o); else n_pass++;
    n_total++; if (arm_o !== 1'b1) $display("FAIL arm_level: got %b want 1", arm_o); else n_pass++;
    n_total++; if (cmd_count_o !== 4'd1) $display("FAIL arm_count: got %0d want 1", cmd_count_o); else n_pass++;
  endtask

  task automatic test_trig;
    run_cmd(3'd2, 0);
    n_total++; if (arm_o !== 1'b0) $display("FAIL disarm_level: got %b want 0", arm_o); else n_pass++;
    run_cmd(3'd3, 0);
    n_total++; if (trig_n !== 0) $display("FAIL trig_disarmed_strobe: got %0d want 0", trig_n); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b1}) $display("FAIL trig_disarmed_stat: got %b want %b1", pio_stat_o, req); else n_pass++;
    run_cmd(3'd1, 0);
    run_cmd(3'd3, 0);
    n_total++; if (trig_n !== 1) $display("FAIL trig_width: got %0d want 1", trig_n); else n_pass++;
    n_total++; if (trig_at !== SYNC + 3) $display("FAIL trig_cycle: got %0d want %0d", trig_at, SYNC + 3); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b0}) $display("FAIL trig_armed_stat: got %b want %b0", pio_stat_o, req); else n_pass++;
  endtask

  task automatic test_warm;
    run_cmd(3'd5, 0);
    n_total++; if (warm_low !== PULSE) $display("FAIL warm_low_cycles: got %0d want %0d", warm_low, PULSE); else n_pass++;
    n_total++; if (lat !== SYNC + 4 + PULSE) $display("FAIL warm_lat: got %0d want %0d", lat, SYNC + 4 + PULSE); else n_pass++;
    n_total++; if (busy_viol !== 0) $display("FAIL warm_busy: got %0d idle cycles want 0", busy_viol); else n_pass++;
    n_total++; if (warm_reset_req_n_o !== 1'b1) $display("FAIL warm_release: got %b want 1", warm_reset_req_n_o); else n_pass++;
  endtask

  task automatic test_wait;
`ifdef PIO_RESP_TIMEOUT_EN
    run_cmd(3'd7, 30);
    n_total++; if (lat !== 32) $display("FAIL wait_done_lat: got %0d want 32", lat); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b0}) $display("FAIL wait_done_stat: got %b want %b0", pio_stat_o, req); else n_pass++;
    run_cmd(3'd7, 0);
    n_total++; if (lat !== SYNC + 4 + TMO) $display("FAIL wait_tmo_lat: got %0d want %0d", lat, SYNC + 4 + TMO); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b1}) $display("FAIL wait_tmo_stat: got %b want %b1", pio_stat_o, req); else n_pass++;
`else
    run_cmd(3'd7, 100);
    n_total++; if (lat !== 102) $display("FAIL wait_done_lat: got %0d want 102", lat); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b0}) $display("FAIL wait_done_stat: got %b want %b0", pio_stat_o, req); else n_pass++;
`endif
  endtask

  task automatic test_reserved;
    run_cmd(3'd6, 0);
    n_total++; if (pio_stat_o !== {req, 1'b1}) $display("FAIL rsvd_stat: got %b want %b1", pio_stat_o, req); else n_pass++;
    n_total++; if (trig_n + clr_n !== 0) $display("FAIL rsvd_strobes: got %0d want 0", trig_n + clr_n); else n_pass++;
    n_total++; if (arm_o !== 1'b1) $display("FAIL rsvd_arm: got %b want 1", arm_o); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (pio_stat_o[0] !== 1'b1) $display("FAIL err_hold: got %b want 1", pio_stat_o[0]); else n_pass++;
  endtask

  task automatic test_clear;
    for (int i = 0; i < 3; i++) run_cmd(3'd0, 0);
    run_cmd(3'd4, 0);
    n_total++; if (clr_n !== 1) $display("FAIL clr_width: got %0d want 1", clr_n); else n_pass++;
    n_total++; if (clr_at !== SYNC + 3) $display("FAIL clr_cycle: got %0d want %0d", clr_at, SYNC + 3); else n_pass++;
    n_total++; if (cmd_count_o !== 4'd0) $display("FAIL clr_count: got %0d want 0", cmd_count_o); else n_pass++;
    n_total++; if (pio_stat_o !== {req, 1'b0}) $display("FAIL clr_stat: got %b want %b0", pio_stat_o, req); else n_pass++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 17; i++) run_cmd(3'd0, 0);
    n_total++; if (cmd_count_o !== 4'd1) $display("FAIL wrap_count: got %0d want 1", cmd_count_o); else n_pass++;
  endtask

  task automatic test_reset_mid;
    req = ~req;
    pio_cmd_i = {req, 3'd5};
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (warm_reset_req_n_o !== 1'b0) $display("FAIL mid_warm_low: got %b want 0", warm_reset_req_n_o); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if (warm_reset_req_n_o !== 1'b1) $display("FAIL mid_warm_rel: got %b want 1", warm_reset_req_n_o); else n_pass++;
    n_total++; if (pio_stat_o !== 2'b00) $display("FAIL mid_stat: got %b want 00", pio_stat_o); else n_pass++;
    req = 1'b0;
    pio_cmd_i = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (pio_stat_o !== 2'b00) $display("FAIL mid_no_ack: got %b want 00", pio_stat_o); else n_pass++;
    run_cmd(3'd0, 0);
    n_total++; if (lat !== SYNC + 4) $display("FAIL reissue_lat: got %0d want %0d", lat, SYNC + 4); else n_pass++;
    n_total++; if (pio_stat_o !== 2'b10) $display("FAIL reissue_stat: got %b want 10", pio_stat_o); else n_pass++;
    n_total++; if (cmd_count_o !== 4'd1) $display("FAIL reissue_count: got %0d want 1", cmd_count_o); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_arm;
    test_trig;
    test_warm;
    test_wait;
    test_reserved;
    test_clear;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
